// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state encoding and line levels.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: bit_tick marks the last cycle of each CLKS_PER_BIT-cycle bit,
// near_tick marks the cycle just before it (never asserted when CLKS_PER_BIT = 1).
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick,
    output logic near_tick
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + TW'(1);
    end

    assign bit_tick = (cnt == LAST);

    generate
        if (CLKS_PER_BIT > 1) begin : g_near
            assign near_tick = (cnt == TW'(CLKS_PER_BIT - 2));
        end else begin : g_no_near
            assign near_tick = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, MSB-first payload, optional even parity, stop bit.
// All outputs are registered; the bit timer is held cleared while idle.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    input  logic              parity_en,
    output logic              ready,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic              parity_q;
    logic              parity_en_q;
    logic [IW-1:0]     bit_idx;
    logic              bit_tick;
    logic              near_tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (ready),
        .bit_tick (bit_tick),
        .near_tick(near_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            serial_out  <= LINE_IDLE;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            shreg       <= '0;
            parity_q    <= 1'b0;
            parity_en_q <= 1'b0;
            bit_idx     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        shreg       <= data;
                        parity_q    <= ^data;
                        parity_en_q <= parity_en;
                        state       <= START;
                        serial_out  <= 1'b0;
                        ready       <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state      <= DATA;
                        serial_out <= shreg[DATA_W-1];
                        shreg      <= shreg << 1;
                        bit_idx    <= '0;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            if (parity_en_q) begin
                                state      <= PARITY;
                                serial_out <= parity_q;
                            end else begin
                                state      <= STOP;
                                serial_out <= LINE_IDLE;
                                done       <= (CLKS_PER_BIT == 1);
                            end
                        end else begin
                            bit_idx    <= bit_idx + IW'(1);
                            serial_out <= shreg[DATA_W-1];
                            shreg      <= shreg << 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state      <= STOP;
                        serial_out <= LINE_IDLE;
                        done       <= (CLKS_PER_BIT == 1);
                    end
                end
                STOP: begin
                    // done is registered, so it is raised one cycle ahead of the final stop cycle
                    if (bit_tick) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        done <= near_tick;
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= LINE_IDLE;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: an 8-bit/4-clock instance and a 4-bit/1-clock instance.
module tb_serial_frame_tx;

    logic clk = 1'b0;
    logic rst;

    logic [7:0] data_a;
    logic       valid_a, par_a;
    logic       ready_a, so_a, busy_a, done_a;

    logic [3:0] data_b;
    logic       valid_b, par_b;
    logic       ready_b, so_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .data(data_a), .valid(valid_a), .parity_en(par_a),
        .ready(ready_a), .serial_out(so_a), .busy(busy_a), .done(done_a)
    );

    serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(rst), .data(data_b), .valid(valid_b), .parity_en(par_b),
        .ready(ready_b), .serial_out(so_b), .busy(busy_b), .done(done_b)
    );

    // Expand a hand-written bit pattern (first bit transmitted = leftmost) to per-cycle samples.
    function automatic logic [127:0] expand(input logic [15:0] pat, input int nbits, input int cpb);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < nbits * cpb; k++)
            r[k] = pat[nbits - 1 - k / cpb];
        return r;
    endfunction

    // Offer one payload to dut_a and record cycles 1..ncyc after the accept edge (index 0 = cycle 1).
    task automatic run_frame(input logic [7:0] d, input logic p, input int ncyc,
                             output logic [127:0] so, output logic [127:0] dn,
                             output logic [127:0] rd, output logic [127:0] bz);
        so = '0; dn = '0; rd = '0; bz = '0;
        @(negedge clk);
        data_a = d; par_a = p; valid_a = 1'b1;
        @(posedge clk);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) valid_a = 1'b0;
            so[i] = so_a; dn[i] = done_a; rd[i] = ready_a; bz[i] = busy_a;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        valid_a = 1'b0; data_a = '0; par_a = 1'b0;
        valid_b = 1'b0; data_b = '0; par_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({so_a, ready_a, busy_a, done_a} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_a: so/ready/busy/done=%b required 1100", {so_a, ready_a, busy_a, done_a});
        end
        checks++;
        if ({so_b, ready_b, busy_b, done_b} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_b: so/ready/busy/done=%b required 1100", {so_b, ready_b, busy_b, done_b});
        end
        // valid during reset must not start a frame
        valid_a = 1'b1; data_a = 8'h55;
        @(negedge clk);
        valid_a = 1'b0;
        checks++;
        if ({so_a, busy_a} !== 2'b10) begin
            failures++;
            $display("FAIL reset_no_accept: so/busy=%b required 10", {so_a, busy_a});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [127:0] so, dn, rd, bz, exp_so, exp_dn;
        exp_so = expand(16'b0101001011, 10, 4);
        exp_dn = '0; exp_dn[39] = 1'b1;
        run_frame(8'hA5, 1'b0, 42, so, dn, rd, bz);
        checks++;
        if (so[41:0] !== {2'b11, exp_so[39:0]}) begin
            failures++;
            $display("FAIL basic_line: got %h required %h", so[41:0], {2'b11, exp_so[39:0]});
        end
        checks++;
        if (dn[41:0] !== exp_dn[41:0]) begin
            failures++;
            $display("FAIL basic_done: got %h required %h", dn[41:0], exp_dn[41:0]);
        end
        checks++;
        if ({rd[0], rd[39], rd[40]} !== 3'b001) begin
            failures++;
            $display("FAIL basic_ready: ready c1/c40/c41=%b required 001", {rd[0], rd[39], rd[40]});
        end
        checks++;
        if ({bz[0], bz[39], bz[40]} !== 3'b110) begin
            failures++;
            $display("FAIL basic_busy: busy c1/c40/c41=%b required 110", {bz[0], bz[39], bz[40]});
        end
    endtask

    task automatic test_parity;
        logic [127:0] so, dn, rd, bz, exp_so, exp_dn;
        exp_so = expand(16'b01010010101, 11, 4);
        exp_dn = '0; exp_dn[43] = 1'b1;
        run_frame(8'hA5, 1'b1, 46, so, dn, rd, bz);
        checks++;
        if (so[45:0] !== {2'b11, exp_so[43:0]}) begin
            failures++;
            $display("FAIL parity_a5_line: got %h required %h", so[45:0], {2'b11, exp_so[43:0]});
        end
        checks++;
        if (dn[45:0] !== exp_dn[45:0] || rd[44] !== 1'b1 || rd[43] !== 1'b0) begin
            failures++;
            $display("FAIL parity_a5_len: done=%h ready c44/c45=%b%b required done=%h ready 01",
                     dn[45:0], rd[43], rd[44], exp_dn[45:0]);
        end
        exp_so = expand(16'b00000011111, 11, 4);
        run_frame(8'h07, 1'b1, 46, so, dn, rd, bz);
        checks++;
        if (so[45:0] !== {2'b11, exp_so[43:0]}) begin
            failures++;
            $display("FAIL parity_07_line: got %h required %h", so[45:0], {2'b11, exp_so[43:0]});
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] so, dn, rd, bz, exp1, exp2, exp_dn;
        so = '0; dn = '0; rd = '0; bz = '0;
        exp1 = expand(16'b0001111001, 10, 4);
        exp2 = expand(16'b0110000111, 10, 4);
        exp_dn = '0; exp_dn[39] = 1'b1; exp_dn[80] = 1'b1;
        @(negedge clk);
        data_a = 8'h3C; par_a = 1'b0; valid_a = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 85; i++) begin
            @(negedge clk);
            if (i == 0) data_a = 8'hC3;
            if (i == 80) valid_a = 1'b0;
            so[i] = so_a; dn[i] = done_a; rd[i] = ready_a; bz[i] = busy_a;
        end
        checks++;
        if (so[39:0] !== exp1[39:0]) begin
            failures++;
            $display("FAIL b2b_frame1: got %h required %h", so[39:0], exp1[39:0]);
        end
        checks++;
        if ({rd[40], bz[40], so[40], rd[41], bz[41]} !== 5'b10101) begin
            failures++;
            $display("FAIL b2b_gap: ready/busy/so c41, ready/busy c42=%b required 10101",
                     {rd[40], bz[40], so[40], rd[41], bz[41]});
        end
        checks++;
        if (so[80:41] !== exp2[39:0]) begin
            failures++;
            $display("FAIL b2b_frame2: got %h required %h", so[80:41], exp2[39:0]);
        end
        checks++;
        if (dn[84:0] !== exp_dn[84:0] || bz[84:81] !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_done: done=%h busy tail=%b required done=%h busy tail 0000",
                     dn[84:0], bz[84:81], exp_dn[84:0]);
        end
    endtask

    task automatic test_busy_stimulus;
        logic [127:0] so, dn, bz, exp_so, exp_dn;
        so = '0; dn = '0; bz = '0;
        exp_so = expand(16'b0101001011, 10, 4);
        exp_dn = '0; exp_dn[39] = 1'b1;
        @(negedge clk);
        data_a = 8'hA5; par_a = 1'b0; valid_a = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            so[i] = so_a; dn[i] = done_a; bz[i] = busy_a;
            data_a = 8'hFF; par_a = 1'b1;
            valid_a = (i < 37) ? i[0] : 1'b0;
        end
        checks++;
        if (so[45:0] !== {6'b111111, exp_so[39:0]}) begin
            failures++;
            $display("FAIL busy_line: got %h required %h", so[45:0], {6'b111111, exp_so[39:0]});
        end
        checks++;
        if (dn[45:0] !== exp_dn[45:0] || bz[45:40] !== 6'b000000) begin
            failures++;
            $display("FAIL busy_extra: done=%h busy tail=%b required done=%h busy tail 000000",
                     dn[45:0], bz[45:40], exp_dn[45:0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] so, dn, rd, bz, exp_so;
        int seen_done;
        @(negedge clk);
        data_a = 8'hA5; par_a = 1'b0; valid_a = 1'b1;
        @(posedge clk);
        // cycles 17..20 carry data bit 3; raise rst during cycle 18
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 1) valid_a = 1'b0;
        end
        checks++;
        if (so_a !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_bit3: so=%b required 0", so_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({so_a, busy_a, ready_a, done_a} !== 4'b1010) begin
            failures++;
            $display("FAIL rstmid_after: so/busy/ready/done=%b required 1010", {so_a, busy_a, ready_a, done_a});
        end
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL rstmid_quiet: done/busy cycles=%0d required 0", seen_done);
        end
        exp_so = expand(16'b0001111001, 10, 4);
        run_frame(8'h3C, 1'b0, 40, so, dn, rd, bz);
        checks++;
        if (so[39:0] !== exp_so[39:0] || dn[39] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_next: line=%h done40=%b required line=%h done40=1", so[39:0], dn[39], exp_so[39:0]);
        end
    endtask

    task automatic test_min_timing;
        logic [15:0] so, dn, rd;
        so = '0; dn = '0; rd = '0;
        @(negedge clk);
        data_b = 4'b1010; par_b = 1'b1; valid_b = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) begin valid_b = 1'b0; data_b = 4'b0101; end
            so[i] = so_b; dn[i] = done_b; rd[i] = ready_b;
        end
        // transmitted order 0,1,0,1,0,0,1 then idle, stored LSB = first cycle
        checks++;
        if (so[8:0] !== 9'b111001010) begin
            failures++;
            $display("FAIL min_line: got %b required 111001010", so[8:0]);
        end
        checks++;
        if (dn[8:0] !== 9'b001000000) begin
            failures++;
            $display("FAIL min_done: got %b required 001000000", dn[8:0]);
        end
        checks++;
        if (rd[8:0] !== 9'b110000000) begin
            failures++;
            $display("FAIL min_ready: got %b required 110000000", rd[8:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_busy_stimulus();
        test_reset_mid();
        test_min_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (legal range 1..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 1 and up).
REQ-003 SHALL have port clk, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port data, input, DATA_W bits; parallel payload.
REQ-006 SHALL have port valid, input, 1 bit; data is offered.
REQ-007 SHALL have port parity_en, input, 1 bit; append an even-parity bit to this frame.
REQ-008 SHALL have port ready, output, 1 bit; the block can accept a payload this cycle.
REQ-009 SHALL have port serial_out, output, 1 bit; serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit; a frame is in progress.
REQ-011 SHALL have port done, output, 1 bit; one-cycle pulse at the end of a frame.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY and STOP.
- IDLE to START on accept.
- START to DATA after one bit time.
- DATA to PARITY after DATA_W bit times if the captured parity_en is 1, otherwise to STOP.
- PARITY to STOP after one bit time.
- STOP to IDLE after one bit time.
REQ-013 SHALL have ready = 1 only in IDLE; accept happens when valid && ready at a rising edge.
REQ-014 SHALL, on accept, capture data and parity_en into internal registers; input changes after accept SHALL have no effect on the current frame.
REQ-015 SHALL drive serial_out from a register (no combinational path from inputs) with these values:
- 1 in IDLE.
- 0 in START.
- Payload MSB-first in DATA.
- XOR of the captured payload in PARITY (even parity).
- 1 in STOP.
REQ-016 SHALL hold each bit on serial_out for exactly CLKS_PER_BIT cycles; the start bit SHALL appear in the cycle after the accept edge.
REQ-017 SHALL make the frame length exactly (DATA_W + 2 + parity) × CLKS_PER_BIT cycles, with no gaps between bits.
REQ-018 SHALL assert done for exactly one cycle, coincident with the last cycle of the stop bit; ready SHALL be 1 in the following cycle.
REQ-019 SHALL give a minimum spacing of one IDLE cycle between frames; a valid held high SHALL start the next frame in that IDLE cycle.
REQ-020 SHALL ignore valid while busy: no queuing, no error.
REQ-021 SHALL have busy = 1 in every state except IDLE.
REQ-022 SHALL size the bit-timer width as $clog2(CLKS_PER_BIT) (minimum 1) and the bit-index width as $clog2(DATA_W) (minimum 1); counters SHALL never wrap past their terminal values.
REQ-023 SHALL operate correctly with CLKS_PER_BIT = 1, i.e. one bit per cycle.

Reset
REQ-024 SHALL, with rst high, force the following on the next edge: state IDLE, serial_out = 1, ready = 1, busy = 0, done = 0, and all counters and the shift register cleared.
REQ-025 SHALL abort an in-progress frame on rst with no done pulse, and SHALL NOT accept valid in a cycle where rst is high.

Structure
REQ-026 SHALL take the state encoding (typedef) and the idle line level constant from a shared package, serial_pkg.
REQ-027 SHALL implement bit timing in one sub-module, bit_timer. It takes clk, rst and a restart input, and produces a one-cycle bit_tick every CLKS_PER_BIT cycles.
REQ-028 SHALL contain the FSM, shift register, parity register and bit counter in the top level.

Verification
REQ-029 SHALL cover a basic frame: DATA_W=8, CLKS_PER_BIT=4, parity_en=0, data=8'hA5. Required response: serial_out = 0,1,0,1,0,0,1,0,1,1 (4 cycles each); done in cycle 40 after accept; ready = 1 in cycle 41.
REQ-030 SHALL cover parity: data=8'hA5 with parity_en=1 gives parity bit 0 and a 44-cycle frame; data=8'h07 gives parity bit 1.
REQ-031 SHALL cover back-to-back frames: valid held high with 8'h3C then 8'hC3. Required response: exactly one IDLE cycle between frames; both frames bit-exact; exactly two done pulses.
REQ-032 SHALL cover busy-time stimulus: change data to 8'hFF and toggle valid during a frame. Required response: the transmitted frame is unchanged and no extra frame is sent.
REQ-033 SHALL cover reset mid-frame: assert rst in DATA bit 3. Required response: next cycle serial_out = 1, busy = 0, ready = 1; no done; the next frame is bit-exact.
REQ-034 SHALL cover minimum timing: CLKS_PER_BIT=1, DATA_W=4, data=4'b1010, parity_en=1. Required response: serial_out = 0,1,0,1,0,0,1 on consecutive cycles; done on the stop-bit cycle.
